// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: opcodes, hazard-controller state encoding,
// flush length and memory-wait saturation limit.
package cpu_pkg;

   localparam int unsigned OPC_W  = 4;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned FCNT_W = 2;

   localparam logic [OPC_W-1:0] OP_NOP = 4'b0000;
   localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
   localparam logic [OPC_W-1:0] OP_BEQ = 4'b0100;
   localparam logic [OPC_W-1:0] OP_LDR = 4'b1001;
   localparam logic [OPC_W-1:0] OP_STR = 4'b1010;

   localparam int unsigned BR_FLUSH_CYCLES = 2;
   localparam int unsigned MEM_WAIT_MAX    = 255;

   typedef enum logic [1:0] {
      ST_RUN        = 2'b00,
      ST_LOAD_STALL = 2'b01,
      ST_BR_FLUSH   = 2'b10,
      ST_MEM_WAIT   = 2'b11
   } state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline hazard control bus.
//   master : drives ID/EX/MEM status (id_*, ex_branch_taken, mem_*), observes controls
//   slave  : hazard controller; drives stall/flush/bubble controls and debug status
interface hazard_controller_if;
   import cpu_pkg::*;

   logic             id_valid;
   logic [OPC_W-1:0] id_opcode;
   logic [REG_W-1:0] id_ra;
   logic [REG_W-1:0] id_rb;
   logic [REG_W-1:0] id_rd;
   logic             ex_branch_taken;
   logic             mem_access;
   logic             mem_ready;

   logic             pc_stall;
   logic             if_id_stall;
   logic             id_ex_stall;
   logic             ex_mem_stall;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic [1:0]       state;
   logic [CNT_W-1:0] mem_wait_cnt;
   logic             mem_timeout;

   modport master (
      output id_valid, id_opcode, id_ra, id_rb, id_rd,
      output ex_branch_taken, mem_access, mem_ready,
      input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
      input  if_id_flush, id_ex_bubble, state, mem_wait_cnt, mem_timeout
   );

   modport slave (
      input  id_valid, id_opcode, id_ra, id_rb, id_rd,
      input  ex_branch_taken, mem_access, mem_ready,
      output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
      output if_id_flush, id_ex_bubble, state, mem_wait_cnt, mem_timeout
   );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
//   i_id_*      : instruction currently in ID
//   i_ex_load_q : EX stage holds a load; i_ex_rd_q is its destination
//   o_hazard_c  : ID instruction reads the register the EX load is producing
module load_use_detect
   import cpu_pkg::*;
(
   input  logic             i_id_valid,
   input  logic [OPC_W-1:0] i_id_opcode,
   input  logic [REG_W-1:0] i_id_ra,
   input  logic [REG_W-1:0] i_id_rb,
   input  logic             i_ex_load_q,
   input  logic [REG_W-1:0] i_ex_rd_q,
   output logic             o_hazard_c
);

   assign o_hazard_c = i_id_valid && i_ex_load_q &&
                       ((i_id_ra == i_ex_rd_q) || (i_id_rb == i_ex_rd_q)) &&
                       (i_id_opcode != OP_NOP);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and
// data-memory wait handling. Controls are decoded combinationally from the
// registered state and current inputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hazard_controller_if.slave (ID/EX/MEM status in, controls out)
module hazard_controller
   import cpu_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   hazard_controller_if.slave  bus
);

   state_t              r_state;
   state_t              r_saved_state;
   logic [FCNT_W-1:0]   r_flush_cnt;
   logic [FCNT_W-1:0]   r_saved_cnt;
   logic                r_br_pend;
   logic [CNT_W-1:0]    r_mem_wait_cnt;
   logic                r_mem_timeout;
   logic                r_ex_load_q;
   logic [REG_W-1:0]    r_ex_rd_q;

   logic                w_hazard;
   logic                w_mem_hold;
   logic                w_branch;
   state_t              w_eff_state;
   logic [FCNT_W-1:0]   w_eff_cnt;
   state_t              w_next_state;
   logic [FCNT_W-1:0]   w_next_cnt;
   logic                w_pc_stall;
   logic                w_if_id_stall;
   logic                w_id_ex_stall;
   logic                w_ex_mem_stall;
   logic                w_flush;
   logic                w_bubble;
   logic                w_any_stall;

   load_use_detect u_load_use_detect (
      .i_id_valid  (bus.id_valid),
      .i_id_opcode (bus.id_opcode),
      .i_id_ra     (bus.id_ra),
      .i_id_rb     (bus.id_rb),
      .i_ex_load_q (r_ex_load_q),
      .i_ex_rd_q   (r_ex_rd_q),
      .o_hazard_c  (w_hazard)
   );

   // Memory stall: a new miss in any state, or a wait still unanswered.
   assign w_mem_hold = !bus.mem_ready && (bus.mem_access || (r_state == ST_MEM_WAIT));

   // On the MEM_WAIT exit cycle the interrupted state resumes its own decode.
   assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_saved_state : r_state;
   assign w_eff_cnt   = (r_state == ST_MEM_WAIT) ? r_saved_cnt   : r_flush_cnt;
   assign w_branch    = bus.ex_branch_taken || r_br_pend;

   // Next-state and control decode; everything is forced low during reset.
   always_comb begin
      w_pc_stall     = 1'b0;
      w_if_id_stall  = 1'b0;
      w_id_ex_stall  = 1'b0;
      w_ex_mem_stall = 1'b0;
      w_flush        = 1'b0;
      w_bubble       = 1'b0;
      w_next_state   = ST_RUN;
      w_next_cnt     = '0;
      if (rst_n) begin
         if (w_mem_hold) begin
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_stall  = 1'b1;
            w_ex_mem_stall = 1'b1;
            w_next_state   = ST_MEM_WAIT;
            w_next_cnt     = r_flush_cnt;
         end else begin
            unique case (w_eff_state)
               ST_RUN, ST_LOAD_STALL: begin
                  if (w_branch) begin
                     // Taken branch discards any pending load-use stall.
                     w_flush      = 1'b1;
                     w_bubble     = 1'b1;
                     w_next_state = ST_BR_FLUSH;
                     w_next_cnt   = FCNT_W'(BR_FLUSH_CYCLES - 1);
                  end else if ((w_eff_state == ST_RUN) && w_hazard) begin
                     w_pc_stall    = 1'b1;
                     w_if_id_stall = 1'b1;
                     w_bubble      = 1'b1;
                     w_next_state  = ST_LOAD_STALL;
                  end
               end
               ST_BR_FLUSH: begin
                  if (w_eff_cnt != '0) begin
                     w_flush      = 1'b1;
                     w_next_state = ST_BR_FLUSH;
                     w_next_cnt   = w_eff_cnt - FCNT_W'(1);
                  end
               end
               default: w_next_state = ST_RUN;
            endcase
         end
      end
   end

   assign w_any_stall = w_pc_stall || w_if_id_stall || w_id_ex_stall || w_ex_mem_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_RUN;
         r_saved_state  <= ST_RUN;
         r_flush_cnt    <= '0;
         r_saved_cnt    <= '0;
         r_br_pend      <= 1'b0;
         r_mem_wait_cnt <= '0;
         r_mem_timeout  <= 1'b0;
         r_ex_load_q    <= 1'b0;
         r_ex_rd_q      <= '0;
      end else begin
         r_state     <= w_next_state;
         r_flush_cnt <= w_next_cnt;

         // Snapshot the interrupted state on MEM_WAIT entry.
         if (w_mem_hold && (r_state != ST_MEM_WAIT)) begin
            r_saved_state <= r_state;
            r_saved_cnt   <= r_flush_cnt;
         end

         // A branch seen while memory stalls is held until the exit cycle.
         r_br_pend <= w_mem_hold && (r_br_pend || bus.ex_branch_taken);

         if (w_mem_hold) begin
            if (r_mem_wait_cnt != CNT_W'(MEM_WAIT_MAX))
               r_mem_wait_cnt <= r_mem_wait_cnt + CNT_W'(1);
            if (r_mem_wait_cnt == CNT_W'(MEM_WAIT_MAX - 1))
               r_mem_timeout <= 1'b1;
         end else begin
            r_mem_wait_cnt <= '0;
         end

         // Track the instruction moving ID -> EX.
         if (w_bubble || w_flush) begin
            r_ex_load_q <= 1'b0;
         end else if (!w_any_stall) begin
            r_ex_load_q <= bus.id_valid && (bus.id_opcode == OP_LDR);
            r_ex_rd_q   <= bus.id_rd;
         end
      end
   end

   assign bus.pc_stall     = w_pc_stall;
   assign bus.if_id_stall  = w_if_id_stall;
   assign bus.id_ex_stall  = w_id_ex_stall;
   assign bus.ex_mem_stall = w_ex_mem_stall;
   assign bus.if_id_flush  = w_flush;
   assign bus.id_ex_bubble = w_bubble;
   assign bus.state        = r_state;
   assign bus.mem_wait_cnt = r_mem_wait_cnt;
   assign bus.mem_timeout  = r_mem_timeout;

endmodule
